// File: rtl/scfifo_plus_pkg.sv
// Shared constants and width helpers for the scfifo_plus FIFO.
package scfifo_plus_pkg;

    localparam int FWFT_REG  = 0;
    localparam int FWFT_SHOW = 1;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy needs one more bit than the pointers so that DEPTH is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/scfifo_plus_ptr.sv
// Binary FIFO pointer: advances by one when enabled and wraps DEPTH-1 -> 0.
module scfifo_plus_ptr
    import scfifo_plus_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    output logic [ptr_width(DEPTH)-1:0] ptr
);

    localparam int AW = ptr_width(DEPTH);

    logic [AW-1:0] ptr_reg;
    logic [AW-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (en) begin
            ptr_next = (ptr_reg == AW'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/scfifo_plus.sv
// Single-clock FIFO with registered or first-word-fall-through read, occupancy flags
// and optional sticky overflow/underflow flags (enabled by SCFIFO_PLUS_ERR_FLAGS_EN).
module scfifo_plus
    import scfifo_plus_pkg::*;
#(
    parameter int WIDTH     = 512,
    parameter int DEPTH     = 8,
    parameter int FWFT      = FWFT_REG,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            i_data_in,
    input  logic                        i_write_en,
    output logic                        i_full_out,
    output logic                        i_almost_full_out,
    output logic [WIDTH-1:0]            o_data_out,
    input  logic                        o_read_en,
    output logic                        o_empty_out,
    output logic                        o_almost_empty_out,
    output logic [cnt_width(DEPTH)-1:0] o_count,
    input  logic                        i_err_clr,
    output logic                        o_overflow,
    output logic                        o_underflow
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic          wr_acc;
    logic          rd_acc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_head;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          full_reg;
    logic          empty_reg;
    logic          afull_reg;
    logic          aempty_reg;
    logic [WIDTH-1:0] data_reg;

    assign wr_acc = i_write_en & ~full_reg;
    assign rd_acc = o_read_en & ~empty_reg;

    scfifo_plus_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_acc),
        .ptr   (wr_ptr)
    );

    scfifo_plus_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rd_acc),
        .ptr   (rd_ptr)
    );

    // Head entry index once this cycle's read (if any) has taken effect.
    assign rd_head = rd_acc ? ((rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1) : rd_ptr;

    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            afull_reg  <= 1'b0;
            aempty_reg <= 1'b1;
        end else begin
            count_reg  <= count_next;
            full_reg   <= (count_next == CW'(DEPTH));
            empty_reg  <= (count_next == '0);
            afull_reg  <= (count_next >= CW'(AF_THRESH));
            aempty_reg <= (count_next <= CW'(AE_THRESH));
        end
    end

    // Storage carries no reset; a reset only discards entries via the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= i_data_in;
        end
    end

    generate
        if (FWFT == FWFT_SHOW) begin : g_fwft
            // Preload the next head; bypass the write data when the head is being written now.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if (count_next != '0) begin
                    data_reg <= (wr_acc && (rd_head == wr_ptr)) ? i_data_in : mem[rd_head];
                end
            end
        end else begin : g_regd
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if (rd_acc) begin
                    data_reg <= mem[rd_ptr];
                end
            end
        end
    endgenerate

`ifdef SCFIFO_PLUS_ERR_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;

    // A new error event takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= (i_write_en & full_reg) | (overflow_reg & ~i_err_clr);
            underflow_reg <= (o_read_en & empty_reg) | (underflow_reg & ~i_err_clr);
        end
    end

    assign o_overflow  = overflow_reg;
    assign o_underflow = underflow_reg;
`else
    logic unused_err_clr;
    assign unused_err_clr = i_err_clr;
    assign o_overflow     = 1'b0;
    assign o_underflow    = 1'b0;
`endif

    assign i_full_out         = full_reg;
    assign i_almost_full_out  = afull_reg;
    assign o_empty_out        = empty_reg;
    assign o_almost_empty_out = aempty_reg;
    assign o_count            = count_reg;
    assign o_data_out         = data_reg;

endmodule

// File: tb/tb_scfifo_plus.sv
// Bench for scfifo_plus: a registered-read and a FWFT instance share stimulus and are
// checked against a queue model; honours SCFIFO_PLUS_ERR_FLAGS_EN for the error flags.
module tb_scfifo_plus;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = 4;
`ifdef SCFIFO_PLUS_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din   = '0;
    logic         wr    = 1'b0;
    logic         rd    = 1'b0;
    logic         clr   = 1'b0;

    logic          full0, afull0, empty0, aempty0, ov0, uf0;
    logic          full1, afull1, empty1, aempty1, ov1, uf1;
    logic [W-1:0]  dout0, dout1;
    logic [CW-1:0] count0, count1;

    always #5 clk = ~clk;

    scfifo_plus #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)) u_reg (
        .clk(clk), .rst_n(rst_n), .i_data_in(din), .i_write_en(wr),
        .i_full_out(full0), .i_almost_full_out(afull0), .o_data_out(dout0),
        .o_read_en(rd), .o_empty_out(empty0), .o_almost_empty_out(aempty0),
        .o_count(count0), .i_err_clr(clr), .o_overflow(ov0), .o_underflow(uf0)
    );

    scfifo_plus #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .i_data_in(din), .i_write_en(wr),
        .i_full_out(full1), .i_almost_full_out(afull1), .o_data_out(dout1),
        .o_read_en(rd), .o_empty_out(empty1), .o_almost_empty_out(aempty1),
        .o_count(count1), .i_err_clr(clr), .o_overflow(ov1), .o_underflow(uf1)
    );

    int total = 0;
    int bad   = 0;
    int step_no = 0;

    // Reference model: contents as a queue, plus the registered-read output and error flags.
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout0;
    logic         m_ov;
    logic         m_uf;

    typedef struct {
        bit           wr;
        bit           rd;
        logic [W-1:0] din;
        int           exp_count;
        logic [3:0]   exp_flags;   // {full, almost_full, empty, almost_empty}
        logic [W-1:0] exp_dout0;
        bit           head_valid;
        logic [W-1:0] exp_head;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [3:0] flags_for(input int n);
        return {n == D, n >= 6, n == 0, n <= 1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout0 = '0;
        m_ov    = 1'b0;
        m_uf    = 1'b0;
    endtask

    task automatic model_update(input bit w, input bit r, input logic [W-1:0] d, input bit c);
        int  n;
        bit  wacc;
        bit  racc;
        n    = q.size();
        wacc = w && (n < D);
        racc = r && (n > 0);
        if (ERR_EN) begin
            m_ov = (w && n == D) || (m_ov && !c);
            m_uf = (r && n == 0) || (m_uf && !c);
        end
        if (racc) m_dout0 = q.pop_front();
        if (wacc) q.push_back(d);
    endtask

    task automatic drive(input bit w, input bit r, input logic [W-1:0] d, input bit c);
        wr = w; rd = r; din = d; clr = c;
        @(posedge clk);
        model_update(w, r, d, c);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
        step_no++;
        $display("step %0d wr=%0b rd=%0b clr=%0b din=%h count=%0d dout_reg=%h dout_fwft=%h",
                 step_no, w, r, c, d, count0, dout0, dout1);
    endtask

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        chk({tag, " count_reg"},  32'(count0), 32'(n));
        chk({tag, " count_fwft"}, 32'(count1), 32'(n));
        chk({tag, " flags_reg"},  32'({full0, afull0, empty0, aempty0}), 32'(flags_for(n)));
        chk({tag, " flags_fwft"}, 32'({full1, afull1, empty1, aempty1}), 32'(flags_for(n)));
        chk({tag, " dout_reg"},   32'(dout0), 32'(m_dout0));
        if (n > 0) chk({tag, " dout_fwft"}, 32'(dout1), 32'(q[0]));
        chk({tag, " err_reg"},    32'({ov0, uf0}), 32'({m_ov, m_uf}));
        chk({tag, " err_fwft"},   32'({ov1, uf1}), 32'({m_ov, m_uf}));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " rst count"}, 32'({count0, count1}), 32'(0));
        chk({tag, " rst flags"}, 32'({full0, afull0, empty0, aempty0, full1, afull1, empty1, aempty1}),
            32'(8'b0011_0011));
        chk({tag, " rst dout"},  32'({dout0, dout1}), 32'(0));
        chk({tag, " rst err"},   32'({ov0, uf0, ov1, uf1}), 32'(0));
    endtask

    initial begin
        // Table: nine writes (last one while full) followed by eight reads.
        for (int i = 0; i < 9; i++) begin
            vecs[i].wr         = 1'b1;
            vecs[i].rd         = 1'b0;
            vecs[i].din        = W'(i + 1);
            vecs[i].exp_count  = (i + 1 > D) ? D : i + 1;
            vecs[i].exp_flags  = flags_for(vecs[i].exp_count);
            vecs[i].exp_dout0  = '0;
            vecs[i].head_valid = 1'b1;
            vecs[i].exp_head   = 16'h0001;
        end
        for (int j = 1; j <= 8; j++) begin
            vecs[8 + j].wr         = 1'b0;
            vecs[8 + j].rd         = 1'b1;
            vecs[8 + j].din        = 16'hDEAD;
            vecs[8 + j].exp_count  = 8 - j;
            vecs[8 + j].exp_flags  = flags_for(8 - j);
            vecs[8 + j].exp_dout0  = W'(j);
            vecs[8 + j].head_valid = (j < 8);
            vecs[8 + j].exp_head   = W'(j + 1);
        end

        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("in_reset");
        rst_n = 1'b1;
        #1 check_reset_values("after_release");

        for (int k = 0; k < 17; k++) begin
            drive(vecs[k].wr, vecs[k].rd, vecs[k].din, 1'b0);
            chk($sformatf("vec%0d count_reg", k),  32'(count0), 32'(vecs[k].exp_count));
            chk($sformatf("vec%0d count_fwft", k), 32'(count1), 32'(vecs[k].exp_count));
            chk($sformatf("vec%0d flags_reg", k),  32'({full0, afull0, empty0, aempty0}), 32'(vecs[k].exp_flags));
            chk($sformatf("vec%0d flags_fwft", k), 32'({full1, afull1, empty1, aempty1}), 32'(vecs[k].exp_flags));
            chk($sformatf("vec%0d dout_reg", k),   32'(dout0), 32'(vecs[k].exp_dout0));
            if (vecs[k].head_valid)
                chk($sformatf("vec%0d dout_fwft", k), 32'(dout1), 32'(vecs[k].exp_head));
            check_model($sformatf("vec%0d model", k));
        end

        // Read while empty, then clear the sticky flags.
        drive(1'b0, 1'b1, 16'h0000, 1'b0);
        check_model("rd_empty");
        chk("uf_set_reg", 32'(uf0), 32'(ERR_EN));
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        check_model("err_clr");
        chk("err_cleared", 32'({ov0, uf0, ov1, uf1}), 32'(0));

        // Single write into empty FIFO becomes visible on the FWFT output without a read.
        drive(1'b1, 1'b0, 16'hABCD, 1'b0);
        check_model("fwft_first");
        chk("fwft_abcd", 32'(dout1), 32'h0000ABCD);
        drive(1'b0, 1'b1, 16'h0000, 1'b0);
        check_model("fwft_drain");

        // Fill, then simultaneous read+write across several pointer wraps.
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 1'b0, W'(16'h0100 + i), 1'b0);
            check_model($sformatf("fill%0d", i));
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, W'(16'h0200 + i), 1'b0);
            check_model($sformatf("rw%0d", i));
        end
        chk("rw_count_7", 32'(count0), 32'(7));
        while (q.size() > 0) begin
            drive(1'b0, 1'b1, 16'h0000, 1'b0);
            check_model("rw_drain");
        end

        // Asynchronous reset with five entries stored.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, W'(16'h0300 + i), 1'b0);
        check_model("pre_reset5");
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 16'h0000, 1'b0);
        check_model("post_rst_read");

        // Randomized traffic with drifting write/read bias to visit full and empty.
        for (int i = 0; i < 600; i++) begin
            int  wb;
            bit  w;
            bit  r;
            wb = ((i / 60) % 2 == 0) ? 75 : 25;
            w  = ($urandom_range(0, 99) < wb);
            r  = ($urandom_range(0, 99) < (100 - wb));
            drive(w, r, W'($urandom), ($urandom_range(0, 15) == 0));
            check_model($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scfifo_plus.md
SCFIFO_PLUS -- requirements
Module: scfifo_plus

Interface
REQ-001 Parameter WIDTH, default 512: data word width in bits, >=1.
REQ-002 Parameter DEPTH, default 8: entry count, power of two, >=2.
REQ-003 Parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 Parameter AF_THRESH, default DEPTH-2: almost-full level, 1..DEPTH.
REQ-005 Parameter AE_THRESH, default 1: almost-empty level, 0..DEPTH-1.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 i_data_in  input  WIDTH  write data.
REQ-009 i_write_en  input  1  write request.
REQ-010 i_full_out  output  1  FIFO full.
REQ-011 i_almost_full_out  output  1  occupancy >= AF_THRESH.
REQ-012 o_data_out  output  WIDTH  read data.
REQ-013 o_read_en  input  1  read request.
REQ-014 o_empty_out  output  1  FIFO empty.
REQ-015 o_almost_empty_out  output  1  occupancy <= AE_THRESH.
REQ-016 o_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-017 i_err_clr  input  1  clears sticky error flags.
REQ-018 o_overflow / o_underflow  output  1 each  sticky error flags.

Function
REQ-019 Write accepted iff i_write_en & ~i_full_out; read accepted iff o_read_en & ~o_empty_out; rejected requests change no state except error flags.
REQ-020 Binary read/write pointers, $clog2(DEPTH) bits, increment by one per accepted access, wrap DEPTH-1 -> 0.
REQ-021 Occupancy register: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds DEPTH, never below 0.
REQ-022 All flags registered, derived from next occupancy: full = (DEPTH), empty = (0), almost-full = (>=AF_THRESH), almost-empty = (<=AE_THRESH); they reflect a write or read on the cycle after acceptance.
REQ-023 When full, simultaneous read+write: read accepted, write rejected, count decreases by 1.
REQ-024 When empty, simultaneous read+write: write accepted, read rejected, count becomes 1.
REQ-025 FWFT=0: o_data_out registered, loaded with head entry on the edge of an accepted read (1-cycle latency), holds otherwise.
REQ-026 FWFT=1: o_data_out presents the head entry whenever o_empty_out=0; an accepted read advances to the next entry on the following cycle; first word visible one cycle after write into empty FIFO.
REQ-027 Data order strictly first-in first-out, including across pointer wrap.

Reset
REQ-028 rst_n low asynchronously forces: pointers 0, o_count 0, o_empty_out 1, i_full_out 0, o_almost_empty_out 1, i_almost_full_out 0, o_data_out 0, o_overflow 0, o_underflow 0.
REQ-029 Reset mid-operation discards all stored entries; storage array itself is not reset.
REQ-030 First accepted access allowed on the first clock edge after rst_n deasserts.

Configuration
REQ-031 Macro SCFIFO_PLUS_ERR_FLAGS_EN defined: o_overflow set on i_write_en while full, o_underflow set on o_read_en while empty, both held until i_err_clr; set wins over simultaneous clear.
REQ-032 Macro undefined: o_overflow and o_underflow tied 0, i_err_clr ignored; ports remain present.

Structure
REQ-033 Package scfifo_plus_pkg holds the FWFT mode constants and function for occupancy width; pointers and widths derived from it.
REQ-034 Sub-module scfifo_plus_ptr: one pointer with enable and wrap, instantiated for read and write.

Verification (WIDTH=16, DEPTH=8, AF_THRESH=6, AE_THRESH=1)
REQ-035 Write 0x0001..0x0008 -> i_almost_full_out rises after 6th write, i_full_out after 8th, o_count=8; 9th write ignored.
REQ-036 Read 8 from full (FWFT=0) -> o_data_out 0x0001..0x0008 each one cycle after read; o_empty_out=1, o_count=0 at end.
REQ-037 FWFT=1, single write 0xABCD to empty -> next cycle o_empty_out=0, o_data_out=0xABCD without read.
REQ-038 Fill 8, then read+write same cycle for 20 cycles -> count stays 7 after first cycle, order preserved across wrap.
REQ-039 With macro: write while full and read while empty -> o_overflow=1, o_underflow=1; pulse i_err_clr -> both 0; without macro both remain 0.
REQ-040 Assert rst_n low with count=5 -> flags and o_count return to reset values same cycle, subsequent read rejected.
